// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan decoder:
// active-low segment constants, scanner state encoding and the pattern decoder.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StHeld
  } scan_state_e;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] value;
  } seg_dec_t;

  // Neither valid nor blank means the pattern is outside the table.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    r = '0;
    case (seg)
      SEG_0:     r = {1'b1, 1'b0, 4'h0};
      SEG_1:     r = {1'b1, 1'b0, 4'h1};
      SEG_2:     r = {1'b1, 1'b0, 4'h2};
      SEG_3:     r = {1'b1, 1'b0, 4'h3};
      SEG_4:     r = {1'b1, 1'b0, 4'h4};
      SEG_5:     r = {1'b1, 1'b0, 4'h5};
      SEG_6:     r = {1'b1, 1'b0, 4'h6};
      SEG_7:     r = {1'b1, 1'b0, 4'h7};
      SEG_8:     r = {1'b1, 1'b0, 4'h8};
      SEG_9:     r = {1'b1, 1'b0, 4'h9};
      SEG_A:     r = {1'b1, 1'b0, 4'hA};
      SEG_B:     r = {1'b1, 1'b0, 4'hB};
      SEG_C:     r = {1'b1, 1'b0, 4'hC};
      SEG_D:     r = {1'b1, 1'b0, 4'hD};
      SEG_E:     r = {1'b1, 1'b0, 4'hE};
      SEG_F:     r = {1'b1, 1'b0, 4'hF};
      SEG_BLANK: r = {1'b0, 1'b1, 4'h0};
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Debounces the sampled {d,seg} pair: a valid pair must be seen STABLE_CYCLES
// consecutive edges before a single capture strobe is issued.
module seg_stable_filter
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic [6:0] seg,
  output logic       cap,
  output logic [7:0] cap_d,
  output logic [6:0] cap_seg
);

  localparam logic [3:0] CntMax = 4'(STABLE_CYCLES);

  scan_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] ref_q, ref_d;
  logic        sel_ok;
  logic        same;

  assign sel_ok = $onehot(~d);
  assign same   = ({d, seg} == ref_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ref_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = {d, seg};
    if (!sel_ok) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (!same || state_q == StIdle) begin
      state_d = StTrack;
      cnt_d   = 4'd1;
    end else if (state_q == StTrack) begin
      if (cnt_q >= CntMax - 4'd1) begin
        state_d = StHeld;
        cnt_d   = CntMax;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    // StHeld with an unchanged pair keeps the saturated count.
  end

  always_comb begin
    cap     = sel_ok && same && (state_q == StTrack) && (cnt_q >= CntMax - 4'd1);
    cap_d   = d;
    cap_seg = seg;
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a scanned, active-low seven-segment display bus and
// keeps one decoded value per digit, plus update/frame/error reporting.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic [6:0] seg,
  input  logic [2:0] rd_sel,
  input  logic       clr_err,
  output logic [3:0] rd_num,
  output logic       rd_valid,
  output logic       digit_update,
  output logic [2:0] upd_idx,
  output logic       frame_done,
  output logic       seg_err
);

  logic       cap;
  logic [7:0] cap_d;
  logic [6:0] cap_seg;

  seg_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .reset  (reset),
    .d      (d),
    .seg    (seg),
    .cap    (cap),
    .cap_d  (cap_d),
    .cap_seg(cap_seg)
  );

  logic [7:0][3:0] value_q;
  logic [7:0]      valid_q;
  logic [7:0]      seen_q;
  logic            err_q;
  logic            upd_q;
  logic [2:0]      idx_q;
  logic            fd_q;

  logic [2:0] cap_idx;
  seg_dec_t   dec;
  logic [7:0] seen_set;
  logic       frame_full;
  logic       cap_bad;

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!cap_d[i]) cap_idx = 3'(i);
    end
    dec        = seg_decode(cap_seg);
    seen_set   = seen_q | (8'b1 << cap_idx);
    frame_full = &seen_set;
    cap_bad    = cap && !dec.valid && !dec.blank;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
      valid_q <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      idx_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      upd_q <= cap;
      fd_q  <= cap && frame_full;
      if (cap) begin
        value_q[cap_idx] <= dec.valid ? dec.value : 4'd0;
        valid_q[cap_idx] <= dec.valid;
        seen_q           <= frame_full ? 8'd0 : seen_set;
        idx_q            <= cap_idx;
      end
      // A fresh invalid capture takes priority over the clear request.
      if (cap_bad) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign rd_num       = value_q[rd_sel];
  assign rd_valid     = valid_q[rd_sel];
  assign digit_update = upd_q;
  assign upd_idx      = idx_q;
  assign frame_done   = fd_q;
  assign seg_err      = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed bench for seg_scan_decoder against a run-length
// reference model of the scan decoder.
module tb_seg_scan_decoder;

  localparam int unsigned S = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic [6:0] seg;
  logic [2:0] rd_sel;
  logic       clr_err;
  logic [3:0] rd_num;
  logic       rd_valid;
  logic       digit_update;
  logic [2:0] upd_idx;
  logic       frame_done;
  logic       seg_err;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .STABLE_CYCLES(S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d           (d),
    .seg         (seg),
    .rd_sel      (rd_sel),
    .clr_err     (clr_err),
    .rd_num      (rd_num),
    .rd_valid    (rd_valid),
    .digit_update(digit_update),
    .upd_idx     (upd_idx),
    .frame_done  (frame_done),
    .seg_err     (seg_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int ups   = 0;
  int fds   = 0;

  logic [6:0]  hex_tab [16];
  logic [14:0] m_prev;
  int          m_run;
  logic [3:0]  m_val [8];
  logic        m_vld [8];
  logic [7:0]  m_mask;
  logic        m_err, m_upd, m_fd;
  logic [2:0]  m_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 15'h7FFF;
    m_run  = 0;
    for (int i = 0; i < 8; i++) begin
      m_val[i] = 4'd0;
      m_vld[i] = 1'b0;
    end
    m_mask = '0;
    m_err  = 1'b0;
    m_upd  = 1'b0;
    m_fd   = 1'b0;
    m_idx  = '0;
  endtask

  // One clock edge worth of behaviour, phrased as run lengths of identical pairs.
  task automatic model_edge(input logic [7:0] dd, input logic [6:0] ss, input logic clr);
    logic        ok;
    logic        cap;
    logic        bad;
    logic [14:0] p;
    int          found;
    int          idx;
    ok = ($countones(~dd) == 1);
    p  = {dd, ss};
    if (ok && p == m_prev) m_run = (m_run > int'(S)) ? m_run : m_run + 1;
    else                   m_run = ok ? 1 : 0;
    m_prev = p;
    cap    = ok && (m_run == int'(S));
    m_upd  = cap;
    m_fd   = 1'b0;
    bad    = 1'b0;
    if (cap) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (!dd[i]) idx = i;
      found = -1;
      for (int k = 0; k < 16; k++) if (hex_tab[k] == ss) found = k;
      if (found >= 0) begin
        m_val[idx] = 4'(found);
        m_vld[idx] = 1'b1;
      end else begin
        m_val[idx] = 4'd0;
        m_vld[idx] = 1'b0;
        bad        = (ss != 7'h7F);
      end
      m_mask[idx] = 1'b1;
      if (&m_mask) begin
        m_fd   = 1'b1;
        m_mask = '0;
      end
      m_idx = 3'(idx);
    end
    if (bad)      m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic check_outputs(input logic [2:0] sel);
    rd_sel = sel;
    #1;
    check_eq("rd_num", 32'(rd_num), 32'(m_val[sel]));
    check_eq("rd_valid", 32'(rd_valid), 32'(m_vld[sel]));
    check_eq("digit_update", 32'(digit_update), 32'(m_upd));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    check_eq("seg_err", 32'(seg_err), 32'(m_err));
    if (m_upd) check_eq("upd_idx", 32'(upd_idx), 32'(m_idx));
    if (digit_update) ups++;
    if (frame_done) fds++;
  endtask

  // Drive inputs for the next rising edge, then check outputs after it.
  task automatic step(input logic [7:0] dd, input logic [6:0] ss, input logic clr,
                      input logic [2:0] sel);
    d       = dd;
    seg     = ss;
    clr_err = clr;
    model_edge(dd, ss, clr);
    @(negedge clk);
    check_outputs(sel);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    d       = 8'hFF;
    seg     = 7'h7F;
    clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs(3'($urandom_range(0, 7)));
    check_eq("rst_upd_idx", 32'(upd_idx), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    int base;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rd_sel = '0;
    do_reset();

    // Single capture of "2" on digit 0.
    for (int i = 0; i < 4; i++) step(8'hFE, 7'h24, 1'b0, 3'd0);
    check_eq("d030_upd", 32'(digit_update), 32'd1);
    check_eq("d030_idx", 32'(upd_idx), 32'd0);
    check_eq("d030_num", 32'(rd_num), 32'd2);
    check_eq("d030_vld", 32'(rd_valid), 32'd1);
    step(8'hFE, 7'h24, 1'b0, 3'd0);
    check_eq("d030_pulse", 32'(digit_update), 32'd0);

    // Pattern change before stability restarts the count.
    base = ups;
    for (int i = 0; i < 3; i++) step(8'hFD, 7'h19, 1'b0, 3'd1);
    for (int i = 0; i < 4; i++) step(8'hFD, 7'h30, 1'b0, 3'd1);
    check_eq("d031_caps", 32'(ups - base), 32'd1);
    check_eq("d031_num", 32'(rd_num), 32'd3);

    // No selection means no capture; blank is not an error.
    base = ups;
    for (int i = 0; i < 10; i++) step((i % 2) ? 8'hFF : 8'h00, 7'h40, 1'b0, 3'd3);
    check_eq("d032_none", 32'(ups - base), 32'd0);
    for (int i = 0; i < 4; i++) step(8'hF7, 7'h7F, 1'b0, 3'd3);
    check_eq("d032_upd", 32'(digit_update), 32'd1);
    check_eq("d032_vld", 32'(rd_valid), 32'd0);
    check_eq("d032_err", 32'(seg_err), 32'd0);

    // Invalid pattern sets a sticky error, cleared by clr_err.
    for (int i = 0; i < 4; i++) step(8'hEF, 7'h55, 1'b0, 3'd4);
    check_eq("d033_set", 32'(seg_err), 32'd1);
    for (int i = 0; i < 3; i++) step(8'hEF, 7'h55, 1'b0, 3'd4);
    check_eq("d033_sticky", 32'(seg_err), 32'd1);
    step(8'hEF, 7'h55, 1'b1, 3'd4);
    check_eq("d033_clr", 32'(seg_err), 32'd0);

    // Full frame scan, then a rescan of one digit.
    do_reset();
    base = ups;
    fds  = 0;
    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < 4; i++) step(~(8'd1 << g), hex_tab[g], 1'b0, 3'(g));
      check_eq("d034_fd", 32'(frame_done), (g == 7) ? 32'd1 : 32'd0);
    end
    check_eq("d034_ups", 32'(ups - base), 32'd8);
    check_eq("d034_fds", 32'(fds), 32'd1);
    step(8'hFF, 7'h7F, 1'b0, 3'd7);
    for (int i = 0; i < 4; i++) step(8'h7F, hex_tab[7], 1'b0, 3'd7);
    check_eq("d034_rescan_upd", 32'(digit_update), 32'd1);
    check_eq("d034_rescan_fd", 32'(frame_done), 32'd0);

    // Reset in the middle of tracking discards progress.
    do_reset();
    for (int i = 0; i < 2; i++) step(8'hBF, 7'h40, 1'b0, 3'd6);
    reset = 1'b0;
    #2;
    model_reset();
    check_outputs(3'd6);
    @(negedge clk);
    reset = 1'b1;
    base  = ups;
    for (int i = 0; i < 3; i++) step(8'hBF, 7'h40, 1'b0, 3'd6);
    check_eq("d035_none", 32'(ups - base), 32'd0);
    step(8'hBF, 7'h40, 1'b0, 3'd6);
    check_eq("d035_upd", 32'(digit_update), 32'd1);
    check_eq("d035_idx", 32'(upd_idx), 32'd6);
    check_eq("d035_num", 32'(rd_num), 32'd0);
    check_eq("d035_vld", 32'(rd_valid), 32'd1);

    // Random bursts of held pairs against the model.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] dd;
      logic [6:0] ss;
      int         hold;
      int         mode;
      mode = $urandom_range(0, 99);
      if (mode < 2) begin
        do_reset();
        continue;
      end
      if (mode < 12) begin
        dd = 8'($urandom);
        if ($countones(~dd) == 1) dd = 8'hFF;
      end else begin
        dd = ~(8'd1 << $urandom_range(0, 7));
      end
      mode = $urandom_range(0, 99);
      if (mode < 70)      ss = hex_tab[$urandom_range(0, 15)];
      else if (mode < 85) ss = 7'h7F;
      else                ss = 7'($urandom);
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) begin
        step(dd, ss, ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4 (legal 2..15): consecutive identical clock samples of d/seg needed before a digit is captured.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 d  input  8  digit enables, active-low, one-hot when valid; d[i]=0 selects digit i.
REQ-005 seg  input  7  segment lines, active-low, {g,f,e,d,c,b,a}.
REQ-006 rd_sel  input  3  readback digit index.
REQ-007 clr_err  input  1  synchronous clear of seg_err.
REQ-008 rd_num  output  4  decoded value of digit rd_sel, combinational from the storage registers.
REQ-009 rd_valid  output  1  digit rd_sel holds a decoded hex value (not blank, not never-captured).
REQ-010 digit_update  output  1  one-cycle pulse on every capture.
REQ-011 upd_idx  output  3  index of the digit captured; meaningful only while digit_update=1.
REQ-012 frame_done  output  1  one-cycle pulse once all 8 digits have been captured since the previous pulse or reset.
REQ-013 seg_err  output  1  sticky flag: a non-table, non-blank pattern was captured.

Function
REQ-014 Decode table (active-low, hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; 7F=blank; any other pattern is invalid.
REQ-015 Scanner FSM states: IDLE (no valid selection), TRACK (counting stability), HELD (captured, waiting for change).
REQ-016 d not exactly one bit low (all high or multiple low) on an edge: go to IDLE, counter cleared, no capture.
REQ-017 Valid {d,seg} differing from the previously sampled pair: go to TRACK, counter=1, store pair as reference.
REQ-018 Pair equal to reference in TRACK: counter increments; edge at which counter reaches STABLE_CYCLES performs the capture and enters HELD.
REQ-019 Capture: digit index = position of the low bit of d; hex pattern stores value and valid=1; blank stores value 0 and valid=0; invalid stores value 0, valid=0, and sets seg_err.
REQ-020 digit_update and upd_idx asserted in the cycle after the capturing edge (registered); rd_num/rd_valid reflect the new value in that same cycle.
REQ-021 In HELD an unchanged pair causes no further capture; any change follows REQ-016/REQ-017.
REQ-022 Captures overwrite a digit's previous value unconditionally.
REQ-023 A per-digit seen mask bit is set on each capture; when the capture makes the mask all-ones, frame_done pulses with digit_update and the mask clears to 0.
REQ-024 clr_err clears seg_err next edge; a new invalid capture on the same edge sets it (set wins).
REQ-025 Counter saturates at STABLE_CYCLES; no wrap.

Reset
REQ-026 reset=0 asynchronously forces: FSM IDLE, counter 0, reference pair all-ones, all digit values 0, all valid 0, seen mask 0, seg_err 0, digit_update 0, upd_idx 0, frame_done 0; rd_num=0, rd_valid=0.
REQ-027 Reset asserted mid-TRACK discards the pending capture; after release a pattern needs a full STABLE_CYCLES samples again.

Structure
REQ-028 Shared package seg_pkg holds the active-low segment constants (SEG_0..SEG_F, SEG_BLANK), the FSM state enum, and the decode function returning {valid, blank, value}.
REQ-029 One sub-module, seg_stable_filter: reference register, comparator, saturating counter and FSM, emitting a capture strobe plus the captured pair; the top holds decode, storage, mask and flags.

Verification
REQ-030 d=FE, seg=24 held 4 edges -> digit_update one cycle with upd_idx=0; rd_sel=0 gives rd_num=2, rd_valid=1.
REQ-031 d=FD, seg=19 held 3 edges then seg=30 for 4 edges -> exactly one capture, rd_sel=1 gives rd_num=3.
REQ-032 d=00 or FF for 10 edges -> no digit_update; d=F7, seg=7F held 4 edges -> rd_sel=3 gives rd_valid=0, seg_err=0.
REQ-033 d=EF, seg=55 held 4 edges -> seg_err=1 and stays 1; clr_err one cycle -> seg_err=0.
REQ-034 Scan digits 0..7 with values 0..7, 4 edges each -> 8 digit_update pulses, frame_done only with the eighth; digit 7 rescan -> no frame_done.
REQ-035 reset low after 2 stable edges of d=BF, seg=40, then release and hold 3 edges -> no capture; fourth edge -> capture of digit 6, value 0.
